// File: rtl/dm_arb_pkg.sv
// Shared definitions for the CPU/NIC data-memory arbiter.
//   state_t    : arbiter FSM states
//   PORT_CPU / PORT_NIC : encoding of a grant / last-grant bit
//   DATA_WIDTH, ADDR_WIDTH, MAX_BURST : default sizing constants
package dm_arb_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;
    localparam int MAX_BURST  = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_NIC = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_XFER  = 2'd1,
        NIC_BURST = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin pick between the CPU and NIC ports.
//   cpu_elig   in  CPU request may be granted this cycle
//   nic_elig   in  NIC request may be granted this cycle
//   last_grant in  port that was served most recently (PORT_CPU/PORT_NIC)
//   grant      out port to serve; only meaningful when either is eligible
module dm_arb_rr
    import dm_arb_pkg::*;
(
    input  logic cpu_elig,
    input  logic nic_elig,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = PORT_CPU;
        if (cpu_elig && nic_elig) begin
            // On a tie, the port that was not served last wins.
            grant = (last_grant == PORT_NIC) ? PORT_CPU : PORT_NIC;
        end else if (nic_elig) begin
            grant = PORT_NIC;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbiter sharing one single-port data memory between a CPU (single-word
// accesses) and a NIC (bursts of 1..MAX_BURST words).
//   clk, rst                         clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU command, held until cpu_ack
//   cpu_ack, cpu_rdata               completion pulse and read data
//   nic_req/we/base/len/wdata        NIC burst command (len = words-1)
//   nic_beat                         beat consumed this cycle
//   nic_rdata, nic_rvalid            registered read beat
//   nic_done                         burst-complete pulse
//   mem_addr/wdata/we, mem_rdata     shared memory port (async read)
module dm_arbiter #(
    parameter int DATA_WIDTH = dm_arb_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dm_arb_pkg::ADDR_WIDTH,
    parameter int MAX_BURST  = dm_arb_pkg::MAX_BURST
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_WIDTH-1:0]        cpu_addr,
    input  logic [DATA_WIDTH-1:0]        cpu_wdata,
    output logic                         cpu_ack,
    output logic [DATA_WIDTH-1:0]        cpu_rdata,
    input  logic                         nic_req,
    input  logic                         nic_we,
    input  logic [ADDR_WIDTH-1:0]        nic_base,
    input  logic [$clog2(MAX_BURST)-1:0] nic_len,
    input  logic [DATA_WIDTH-1:0]        nic_wdata,
    output logic                         nic_beat,
    output logic [DATA_WIDTH-1:0]        nic_rdata,
    output logic                         nic_rvalid,
    output logic                         nic_done,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic                         mem_we,
    input  logic [DATA_WIDTH-1:0]        mem_rdata
);

    import dm_arb_pkg::*;

    localparam int BEAT_W = $clog2(MAX_BURST);

    state_t                  state_reg, state_next;
    logic                    last_grant_reg;
    logic                    owner_reg;
    logic                    cmd_we_reg;
    logic [ADDR_WIDTH-1:0]   cmd_addr_reg;
    logic [DATA_WIDTH-1:0]   cmd_wdata_reg;
    logic [BEAT_W-1:0]       cmd_len_reg;
    logic [BEAT_W-1:0]       beat_reg;
    logic [DATA_WIDTH-1:0]   cpu_rdata_reg;
    logic [DATA_WIDTH-1:0]   nic_rdata_reg;
    logic                    nic_rvalid_reg;
    // Last driven memory address/data, held while the port is not in use.
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;

    logic cpu_elig, nic_elig, grant, take;

    // A port whose completion pulse is high is still holding a request
    // that has already been served; it must not be granted again.
    assign cpu_elig = cpu_req && !cpu_ack;
    assign nic_elig = nic_req && !nic_done;

    dm_arb_rr u_rr (
        .cpu_elig   (cpu_elig),
        .nic_elig   (nic_elig),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        mem_addr   = mem_addr_reg;
        mem_wdata  = mem_wdata_reg;
        mem_we     = 1'b0;
        nic_beat   = 1'b0;
        cpu_ack    = 1'b0;
        nic_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_elig || nic_elig) begin
                    take       = 1'b1;
                    state_next = (grant == PORT_CPU) ? CPU_XFER : NIC_BURST;
                end
            end
            CPU_XFER: begin
                mem_addr   = cmd_addr_reg;
                mem_wdata  = cmd_wdata_reg;
                mem_we     = cmd_we_reg;
                state_next = DONE;
            end
            NIC_BURST: begin
                // Address wraps naturally at the top of the address space.
                mem_addr = cmd_addr_reg + ADDR_WIDTH'(beat_reg);
                mem_we   = cmd_we_reg;
                nic_beat = 1'b1;
                if (cmd_we_reg) begin
                    mem_wdata = nic_wdata;
                end
                if (beat_reg == cmd_len_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_ack    = (owner_reg == PORT_CPU);
                nic_done   = (owner_reg == PORT_NIC);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= PORT_NIC;
            owner_reg      <= PORT_CPU;
            cmd_we_reg     <= 1'b0;
            cmd_addr_reg   <= '0;
            cmd_wdata_reg  <= '0;
            cmd_len_reg    <= '0;
            beat_reg       <= '0;
            cpu_rdata_reg  <= '0;
            nic_rdata_reg  <= '0;
            nic_rvalid_reg <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            mem_addr_reg   <= mem_addr;
            mem_wdata_reg  <= mem_wdata;
            nic_rvalid_reg <= 1'b0;
            if (take) begin
                owner_reg <= grant;
                beat_reg  <= '0;
                if (grant == PORT_CPU) begin
                    cmd_we_reg    <= cpu_we;
                    cmd_addr_reg  <= cpu_addr;
                    cmd_wdata_reg <= cpu_wdata;
                end else begin
                    cmd_we_reg   <= nic_we;
                    cmd_addr_reg <= nic_base;
                    cmd_len_reg  <= nic_len;
                end
            end
            case (state_reg)
                CPU_XFER: cpu_rdata_reg <= mem_rdata;
                NIC_BURST: begin
                    beat_reg <= beat_reg + BEAT_W'(1);
                    if (!cmd_we_reg) begin
                        nic_rvalid_reg <= 1'b1;
                        nic_rdata_reg  <= mem_rdata;
                    end
                end
                DONE: last_grant_reg <= owner_reg;
                default: ;
            endcase
        end
    end

    assign cpu_rdata  = cpu_rdata_reg;
    assign nic_rdata  = nic_rdata_reg;
    assign nic_rvalid = nic_rvalid_reg;

endmodule
